// File: rtl/inst_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction queue.
// slave modport: the queue itself; master modport: fetch unit / decoder side.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

interface inst_queue_if #(
  parameter int unsigned DEPTH_LOG = 4
);
  localparam int unsigned AW    = `ADDR_WIDTH;
  localparam int unsigned CNT_W = DEPTH_LOG + 1;

  // fetch side
  logic             valid_if_in;
  logic [31:0]      inst_if_in;
  logic [AW-1:0]    pc_if_in;
  logic             full_if_out;
  // decode side
  logic [31:0]      inst_dec_out;
  logic [AW-1:0]    pc_dec_out;
  logic             rdy_dec_out;
  logic             rdy_dispatch_dec_in;
  // status
  logic [CNT_W-1:0] count_out;

  modport slave (
    input  valid_if_in, inst_if_in, pc_if_in, rdy_dispatch_dec_in,
    output full_if_out, inst_dec_out, pc_dec_out, rdy_dec_out, count_out
  );

  modport master (
    output valid_if_in, inst_if_in, pc_if_in, rdy_dispatch_dec_in,
    input  full_if_out, inst_dec_out, pc_dec_out, rdy_dec_out, count_out
  );
endinterface

// File: rtl/inst_queue.sv
// Instruction queue: circular show-ahead FIFO between fetch and decode.
// Optional macro IQ_BYPASS_EN: an empty queue forwards the fetched word to
// the decoder in the same cycle, and drops it if the decoder takes it.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module inst_queue #(
  parameter int unsigned DEPTH_LOG = 4
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic         rdy_in,
  input  logic         clear_in,
  inst_queue_if.slave  iq
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG;
  localparam int unsigned CNT_W = DEPTH_LOG + 1;
  localparam int unsigned AW    = `ADDR_WIDTH;
  localparam int unsigned IW    = 32;

  logic [DEPTH_LOG-1:0] head_q, head_d;
  logic [DEPTH_LOG-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic [IW-1:0] inst_mem_q [DEPTH];
  logic [AW-1:0] pc_mem_q   [DEPTH];

  logic full_c;
  logic nonempty_c;
  logic bypass_c;
  logic bypass_take_c;
  logic rdy_dec_c;
  logic wr_en_c;
  logic rd_en_c;

  // occupancy flags
  assign full_c     = (count_q == CNT_W'(DEPTH));
  assign nonempty_c = (count_q != '0);

  // same-cycle forwarding of the fetched word into an empty queue
`ifdef IQ_BYPASS_EN
  assign bypass_c = ~nonempty_c & rdy_in & iq.valid_if_in & ~clear_in;
`else
  assign bypass_c = 1'b0;
`endif
  assign bypass_take_c = bypass_c & iq.rdy_dispatch_dec_in;

  assign rdy_dec_c = nonempty_c | bypass_c;

  // a forwarded word consumed by the decoder never lands in storage;
  // a pop only ever removes a stored entry, so an empty queue cannot underflow
  assign wr_en_c = rdy_in & iq.valid_if_in & ~full_c & ~clear_in & ~bypass_take_c;
  assign rd_en_c = rdy_in & nonempty_c & iq.rdy_dispatch_dec_in & ~clear_in;

  // pointer and counter next-state; clear outranks push/pop, rdy_in low freezes
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rdy_in) begin
      if (clear_in) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (wr_en_c) tail_d = tail_q + DEPTH_LOG'(1);
        if (rd_en_c) head_d = head_q + DEPTH_LOG'(1);
        case ({wr_en_c, rd_en_c})
          2'b10:   count_d = count_q + CNT_W'(1);
          2'b01:   count_d = count_q - CNT_W'(1);
          default: count_d = count_q;
        endcase
      end
    end
  end

  // pointer and counter registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // entry storage; not reset, contents are only visible while count != 0
  always_ff @(posedge clk_in) begin
    if (wr_en_c) begin
      inst_mem_q[tail_q] <= iq.inst_if_in;
      pc_mem_q[tail_q]   <= iq.pc_if_in;
    end
  end

  // head presentation to the decoder
  always_comb begin
    iq.inst_dec_out = '0;
    iq.pc_dec_out   = '0;
    if (nonempty_c) begin
      iq.inst_dec_out = inst_mem_q[head_q];
      iq.pc_dec_out   = pc_mem_q[head_q];
    end else if (bypass_c) begin
      iq.inst_dec_out = iq.inst_if_in;
      iq.pc_dec_out   = iq.pc_if_in;
    end
  end

  assign iq.full_if_out = full_c;
  assign iq.rdy_dec_out = rdy_dec_c;
  assign iq.count_out   = count_q;

  // structural invariants: bounded occupancy, pointers consistent with count
  always_ff @(posedge clk_in) begin
    if (rst_n_in) begin
      assert (count_q <= CNT_W'(DEPTH))
        else $error("inst_queue: occupancy above depth");
      assert ((tail_q - head_q) == count_q[DEPTH_LOG-1:0])
        else $error("inst_queue: pointers disagree with occupancy");
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: scoreboard queue models the FIFO.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_inst_queue;
  localparam int unsigned DEPTH_LOG = 4;
  localparam int unsigned DEPTH     = 1 << DEPTH_LOG;
  localparam int unsigned AW        = `ADDR_WIDTH;

  typedef struct {
    logic [31:0]   inst;
    logic [AW-1:0] pc;
  } entry_t;

  logic clk;
  logic rst_n;
  logic rdy;
  logic clear;

  entry_t sb[$];
  int     n_checks;
  int     n_pass;

  inst_queue_if #(.DEPTH_LOG(DEPTH_LOG)) iq ();

  inst_queue #(.DEPTH_LOG(DEPTH_LOG)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .rdy_in   (rdy),
    .clear_in (clear),
    .iq       (iq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
  endtask

  // One clock: drive inputs just after negedge, check settled outputs against
  // the scoreboard, update the model, then advance to the next negedge.
  task automatic cycle(input logic v, input logic [31:0] inst, input logic [AW-1:0] pc,
                       input logic disp, input logic r, input logic clr);
    entry_t e;
    logic   byp;
    logic   do_push;
    logic   do_pop;
    iq.valid_if_in         = v;
    iq.inst_if_in          = inst;
    iq.pc_if_in            = pc;
    iq.rdy_dispatch_dec_in = disp;
    rdy                    = r;
    clear                  = clr;
    #1;
`ifdef IQ_BYPASS_EN
    byp = (sb.size() == 0) && v && r && !clr;
`else
    byp = 1'b0;
`endif
    chk("count", 64'(iq.count_out), 64'(sb.size()));
    chk("full", 64'(iq.full_if_out), 64'(sb.size() == DEPTH));
    chk("rdy_dec", 64'(iq.rdy_dec_out), 64'((sb.size() != 0) || byp));
    do_pop  = r && !clr && disp && (sb.size() != 0);
    do_push = r && !clr && v && (sb.size() < DEPTH) && !(byp && disp);
    if (do_pop) begin
      e = sb.pop_front();
      chk("pop_inst", 64'(iq.inst_dec_out), 64'(e.inst));
      chk("pop_pc", 64'(iq.pc_dec_out), 64'(e.pc));
    end else if (sb.size() != 0) begin
      chk("head_inst", 64'(iq.inst_dec_out), 64'(sb[0].inst));
      chk("head_pc", 64'(iq.pc_dec_out), 64'(sb[0].pc));
    end else if (byp) begin
      chk("byp_inst", 64'(iq.inst_dec_out), 64'(inst));
      chk("byp_pc", 64'(iq.pc_dec_out), 64'(pc));
    end else begin
      chk("empty_inst", 64'(iq.inst_dec_out), 64'd0);
      chk("empty_pc", 64'(iq.pc_dec_out), 64'd0);
    end
    if (r && clr) sb.delete();
    else if (do_push) begin
      e.inst = inst;
      e.pc   = pc;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic drain;
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 32'd0, '0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic push_n(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++)
      cycle(1'b1, base + 32'(i), AW'(32'h1000 + 4 * i), 1'b0, 1'b1, 1'b0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_count"}, 64'(iq.count_out), 64'd0);
    chk({tag, "_rdy"}, 64'(iq.rdy_dec_out), 64'd0);
    chk({tag, "_full"}, 64'(iq.full_if_out), 64'd0);
    chk({tag, "_inst"}, 64'(iq.inst_dec_out), 64'd0);
    chk({tag, "_pc"}, 64'(iq.pc_dec_out), 64'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    rdy      = 1'b0;
    clear    = 1'b0;
    iq.valid_if_in         = 1'b0;
    iq.inst_if_in          = '0;
    iq.pc_if_in            = '0;
    iq.rdy_dispatch_dec_in = 1'b0;
    #1;
    reset_checks("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // single push, visible the following cycle
    cycle(1'b1, 32'h0050_0093, '0, 1'b0, 1'b1, 1'b0);
    chk("first_head", 64'(iq.inst_dec_out), 64'h0050_0093);
    idle(1);
    drain();

    // offset pointers, then fill, overflow attempt, drain in order across wrap
    push_n(3, 32'hA000_0000);
    drain();
    push_n(DEPTH, 32'hB000_0000);
    cycle(1'b1, 32'hDEAD_BEEF, AW'(32'hFFC), 1'b0, 1'b1, 1'b0);
    chk("full_hold", 64'(iq.count_out), 64'(DEPTH));
    drain();

    // steady-state push+pop at occupancy 5
    push_n(5, 32'hC000_0000);
    for (int i = 0; i < 40; i++)
      cycle(1'b1, 32'hC100_0000 + 32'(i), AW'(32'h2000 + 4 * i), 1'b1, 1'b1, 1'b0);
    drain();

    // clear with simultaneous push at occupancy 7
    push_n(7, 32'hD000_0000);
    cycle(1'b1, 32'hBAD0_0001, AW'(32'h3000), 1'b1, 1'b1, 1'b1);
    chk("clr_count", 64'(iq.count_out), 64'd0);
    cycle(1'b1, 32'hD100_0000, AW'(32'h3004), 1'b0, 1'b1, 1'b0);
    drain();

    // stall: rdy_in low with fetch and dispatch active
    push_n(3, 32'hE000_0000);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'hE100_0000 + 32'(i), AW'(32'h4000), 1'b1, 1'b0, 1'b0);
    chk("stall_count", 64'(iq.count_out), 64'd3);
    drain();

`ifdef IQ_BYPASS_EN
    // empty queue with push and dispatch together: forwarded, not stored
    cycle(1'b1, 32'hF000_0001, AW'(32'h5000), 1'b1, 1'b1, 1'b0);
    chk("byp_count", 64'(iq.count_out), 64'd0);
    // empty queue with push only: forwarded view and stored
    cycle(1'b1, 32'hF000_0002, AW'(32'h5004), 1'b0, 1'b1, 1'b0);
    drain();
`endif

    // random traffic
    for (int i = 0; i < 200; i++)
      cycle(1'(($urandom_range(0, 3)) != 0), $urandom, AW'($urandom),
            1'($urandom_range(0, 1)), 1'(($urandom_range(0, 7)) != 0),
            1'(($urandom_range(0, 31)) == 0));

    // asynchronous reset mid-operation loses all entries
    push_n(4, 32'h7000_0000);
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks("mid_rst");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 32'h7100_0000, AW'(32'h6000), 1'b0, 1'b1, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
